// File: rtl/submarine_pkg.sv
// rtl/submarine_pkg.sv - shared constants, state encodings and helpers for the submarine game controller
package submarine_pkg;

    localparam int GRID_BITS  = 3;
    localparam int GRID_CELLS = 64;
    localparam int IDX_W      = 2 * GRID_BITS;

    localparam logic [1:0] BOARD_0 = 2'd0;
    localparam logic [1:0] BOARD_1 = 2'd1;
    localparam logic [1:0] BOARD_2 = 2'd2;
    localparam logic [1:0] BOARD_3 = 2'd3;

    localparam int STATE_W = 4;
    localparam logic [3:0] ST_IDLE      = 4'd0;
    localparam logic [3:0] ST_ENG_RST   = 4'd1;
    localparam logic [3:0] ST_READY     = 4'd2;
    localparam logic [3:0] ST_ISSUE     = 4'd3;
    localparam logic [3:0] ST_WAIT_ACK  = 4'd4;
    localparam logic [3:0] ST_WAIT_DONE = 4'd5;
    localparam logic [3:0] ST_CAPTURE   = 4'd6;
    localparam logic [3:0] ST_RESULT    = 4'd7;
    localparam logic [3:0] ST_OVER      = 4'd8;

    function automatic logic [IDX_W-1:0] cell_idx(input logic [GRID_BITS-1:0] x,
                                                  input logic [GRID_BITS-1:0] y);
        return {y, x};
    endfunction

endpackage

// File: rtl/shot_bitmap.sv
// rtl/shot_bitmap.sv - 64-cell fired-shot map with clear, set and combinational test
module shot_bitmap
    import submarine_pkg::*;
(
    input  logic             clk,
    input  logic             rstn,
    input  logic             clr,
    input  logic             set_en,
    input  logic [IDX_W-1:0] set_idx,
    input  logic [IDX_W-1:0] test_idx,
    output logic             test_hit
);

    logic [GRID_CELLS-1:0] map_q;
    logic [GRID_CELLS-1:0] map_d;

    always_comb begin
        map_d = map_q;
        if (clr) begin
            map_d = '0;
        end else if (set_en) begin
            map_d[set_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            map_q <= '0;
        end else begin
            map_q <= map_d;
        end
    end

    assign test_hit = map_q[test_idx];

endmodule

// File: rtl/submarine_game_ctrl.sv
// rtl/submarine_game_ctrl.sv - shot sequencer and game manager in front of the submarine board engine
module submarine_game_ctrl
    import submarine_pkg::*;
#(
    parameter int MAX_SHOTS   = 40,
    parameter int ACK_TIMEOUT = 4,
    parameter int CNT_W       = 6
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 start,
    input  logic [1:0]           board_sel,
    input  logic                 shot_valid,
    input  logic [GRID_BITS-1:0] shot_x,
    input  logic [GRID_BITS-1:0] shot_y,
    output logic                 shot_ready,
    output logic                 res_valid,
    output logic                 res_hit,
    output logic                 res_sink,
    output logic                 res_dup,
    output logic                 game_over,
    output logic                 game_won,
    output logic [CNT_W-1:0]     shots_used,
    output logic [CNT_W-1:0]     hits,
    output logic [3:0]           sinks,
    output logic                 eng_rstn,
    output logic [1:0]           eng_init_select,
    output logic                 eng_cord_valid,
    output logic [GRID_BITS-1:0] eng_x,
    output logic [GRID_BITS-1:0] eng_y,
    input  logic                 eng_busy,
    input  logic                 eng_hit,
    input  logic                 eng_sink,
    input  logic                 eng_done
);

    localparam int TO_W = (ACK_TIMEOUT < 1) ? 1 : $clog2(ACK_TIMEOUT + 1);

    logic [STATE_W-1:0]   state_q, state_d;
    logic [GRID_BITS-1:0] ex_q, ex_d, ey_q, ey_d;
    logic [1:0]           sel_q, sel_d;
    logic                 res_hit_q, res_hit_d, res_sink_q, res_sink_d, res_dup_q, res_dup_d;
    logic                 done_q, done_d, over_q, over_d, won_q, won_d;
    logic [CNT_W-1:0]     shots_q, shots_d, hits_q, hits_d;
    logic [3:0]           sinks_q, sinks_d;
    logic [TO_W-1:0]      to_q, to_d;
    logic                 bm_clr, bm_set, bm_dup;

    shot_bitmap u_bitmap (
        .clk      (clk),
        .rstn     (rstn),
        .clr      (bm_clr),
        .set_en   (bm_set),
        .set_idx  (cell_idx(ex_q, ey_q)),
        .test_idx (cell_idx(shot_x, shot_y)),
        .test_hit (bm_dup)
    );

    assign bm_clr = (state_q == ST_ENG_RST);
    assign bm_set = (state_q == ST_ISSUE);

    always_comb begin
        state_d    = state_q;
        ex_d       = ex_q;
        ey_d       = ey_q;
        sel_d      = sel_q;
        res_hit_d  = res_hit_q;
        res_sink_d = res_sink_q;
        res_dup_d  = res_dup_q;
        done_d     = done_q;
        over_d     = over_q;
        won_d      = won_q;
        shots_d    = shots_q;
        hits_d     = hits_q;
        sinks_d    = sinks_q;
        to_d       = to_q;

        // start overrides everything, including an in-flight shot and a same-cycle accept
        if (start) begin
            state_d = ST_ENG_RST;
            sel_d   = board_sel;
        end else begin
            case (state_q)
                ST_IDLE: ;
                ST_ENG_RST: begin
                    shots_d = '0;
                    hits_d  = '0;
                    sinks_d = '0;
                    over_d  = 1'b0;
                    won_d   = 1'b0;
                    done_d  = 1'b0;
                    to_d    = '0;
                    state_d = ST_READY;
                end
                ST_READY: begin
                    if (shot_valid) begin
                        res_dup_d = bm_dup;
                        if (bm_dup) begin
                            // repeats skip the engine but pass through CAPTURE to keep a 2-cycle result
                            res_hit_d  = 1'b0;
                            res_sink_d = 1'b0;
                            state_d    = ST_CAPTURE;
                        end else begin
                            ex_d    = shot_x;
                            ey_d    = shot_y;
                            state_d = ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (shots_q != '1) shots_d = shots_q + 1'b1;
                    to_d    = '0;
                    state_d = ST_WAIT_ACK;
                end
                ST_WAIT_ACK: begin
                    if (eng_busy) begin
                        state_d = ST_WAIT_DONE;
                    end else if (to_q == TO_W'(ACK_TIMEOUT)) begin
                        state_d = ST_CAPTURE;
                    end else begin
                        to_d = to_q + 1'b1;
                    end
                end
                ST_WAIT_DONE: begin
                    if (!eng_busy) state_d = ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    if (res_dup_q) begin
                        done_d = 1'b0;
                    end else begin
                        res_hit_d  = eng_hit;
                        res_sink_d = eng_sink;
                        done_d     = eng_done;
                        if (eng_hit && hits_q != '1) hits_d = hits_q + 1'b1;
                        if (eng_sink && sinks_q != 4'hf) sinks_d = sinks_q + 1'b1;
                    end
                    state_d = ST_RESULT;
                end
                ST_RESULT: begin
                    if (done_q) begin
                        over_d  = 1'b1;
                        won_d   = 1'b1;
                        state_d = ST_OVER;
                    end else if (shots_q == CNT_W'(MAX_SHOTS)) begin
                        over_d  = 1'b1;
                        won_d   = 1'b0;
                        state_d = ST_OVER;
                    end else begin
                        state_d = ST_READY;
                    end
                end
                ST_OVER: ;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            ex_q       <= '0;
            ey_q       <= '0;
            sel_q      <= '0;
            res_hit_q  <= 1'b0;
            res_sink_q <= 1'b0;
            res_dup_q  <= 1'b0;
            done_q     <= 1'b0;
            over_q     <= 1'b0;
            won_q      <= 1'b0;
            shots_q    <= '0;
            hits_q     <= '0;
            sinks_q    <= '0;
            to_q       <= '0;
        end else begin
            state_q    <= state_d;
            ex_q       <= ex_d;
            ey_q       <= ey_d;
            sel_q      <= sel_d;
            res_hit_q  <= res_hit_d;
            res_sink_q <= res_sink_d;
            res_dup_q  <= res_dup_d;
            done_q     <= done_d;
            over_q     <= over_d;
            won_q      <= won_d;
            shots_q    <= shots_d;
            hits_q     <= hits_d;
            sinks_q    <= sinks_d;
            to_q       <= to_d;
        end
    end

    assign shot_ready      = (state_q == ST_READY);
    assign res_valid       = (state_q == ST_RESULT);
    assign res_hit         = res_hit_q;
    assign res_sink        = res_sink_q;
    assign res_dup         = res_dup_q;
    assign game_over       = over_q;
    assign game_won        = won_q;
    assign shots_used      = shots_q;
    assign hits            = hits_q;
    assign sinks           = sinks_q;
    assign eng_rstn        = (state_q != ST_IDLE) && (state_q != ST_ENG_RST);
    assign eng_init_select = sel_q;
    assign eng_cord_valid  = (state_q == ST_ISSUE);
    assign eng_x           = ex_q;
    assign eng_y           = ey_q;

endmodule

// File: tb/tb_submarine_game_ctrl.sv
// tb/tb_submarine_game_ctrl.sv - directed bench for submarine_game_ctrl with a small board-engine model
module tb_submarine_game_ctrl;

    logic       clk = 1'b0;
    logic       rstn, start, shot_valid;
    logic [1:0] board_sel;
    logic [2:0] shot_x, shot_y;
    logic       shot_ready, res_valid, res_hit, res_sink, res_dup, game_over, game_won;
    logic [5:0] shots_used, hits;
    logic [3:0] sinks;
    logic       eng_rstn, eng_cord_valid;
    logic [1:0] eng_init_select;
    logic [2:0] eng_x, eng_y;
    logic       eng_busy, eng_hit, eng_sink, eng_done;

    int n_run  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    submarine_game_ctrl #(.MAX_SHOTS(4), .ACK_TIMEOUT(4), .CNT_W(6)) dut (
        .clk(clk), .rstn(rstn), .start(start), .board_sel(board_sel),
        .shot_valid(shot_valid), .shot_x(shot_x), .shot_y(shot_y), .shot_ready(shot_ready),
        .res_valid(res_valid), .res_hit(res_hit), .res_sink(res_sink), .res_dup(res_dup),
        .game_over(game_over), .game_won(game_won), .shots_used(shots_used), .hits(hits),
        .sinks(sinks), .eng_rstn(eng_rstn), .eng_init_select(eng_init_select),
        .eng_cord_valid(eng_cord_valid), .eng_x(eng_x), .eng_y(eng_y),
        .eng_busy(eng_busy), .eng_hit(eng_hit), .eng_sink(eng_sink), .eng_done(eng_done)
    );

    // Board 0: ship A at (3,0),(3,1); ship B at (5,5). Index is {y,x}.
    localparam logic [63:0] SHIP_A = (64'd1 << 3) | (64'd1 << 11);
    localparam logic [63:0] SHIP_B = (64'd1 << 45);

    logic [63:0] rem_q;
    logic        p_hit, p_sink, p_done;
    int          busy_cnt;
    int          busy_len = 2;
    bit          no_busy  = 1'b0;

    logic [5:0]  m_idx;
    logic        m_hit, m_sink, m_done;
    logic [63:0] m_rem;
    assign m_idx  = {eng_y, eng_x};
    assign m_hit  = rem_q[m_idx];
    assign m_rem  = rem_q & ~(64'd1 << m_idx);
    assign m_sink = m_hit && ((m_rem & (SHIP_A[m_idx] ? SHIP_A : SHIP_B)) == 64'd0);
    assign m_done = m_hit && (m_rem == 64'd0);

    always @(posedge clk) begin
        if (!eng_rstn) begin
            rem_q    <= SHIP_A | SHIP_B;
            eng_busy <= 1'b0;
            eng_hit  <= 1'b0;
            eng_sink <= 1'b0;
            eng_done <= 1'b0;
            busy_cnt <= 0;
        end else if (eng_cord_valid) begin
            rem_q <= m_rem;
            if (no_busy) begin
                eng_hit  <= m_hit;
                eng_sink <= m_sink;
                eng_done <= m_done;
            end else begin
                eng_busy <= 1'b1;
                busy_cnt <= busy_len;
                p_hit    <= m_hit;
                p_sink   <= m_sink;
                p_done   <= m_done;
            end
        end else if (eng_busy) begin
            if (busy_cnt == 1) begin
                eng_busy <= 1'b0;
                eng_hit  <= p_hit;
                eng_sink <= p_sink;
                eng_done <= p_done;
            end
            busy_cnt <= busy_cnt - 1;
        end
    end

    task automatic do_start(input logic [1:0] sel);
        start = 1'b1; board_sel = sel;
        @(negedge clk);
        start = 1'b0;
        n_run++;
        if (eng_rstn !== 1'b0) begin n_fail++; $display("FAIL start_eng_rstn: got %0b want 0", eng_rstn); end
        @(negedge clk);
        n_run++;
        if (shot_ready !== 1'b1 || eng_rstn !== 1'b1) begin
            n_fail++; $display("FAIL start_ready: shot_ready=%0b eng_rstn=%0b want 1 1", shot_ready, eng_rstn);
        end
    endtask

    task automatic fire(input logic [2:0] x, input logic [2:0] y, output bit got,
                        output logic h, output logic s, output logic d,
                        output int lat, output int cords);
        got = 1'b0; lat = 0; cords = 0; h = 1'bx; s = 1'bx; d = 1'bx;
        shot_x = x; shot_y = y; shot_valid = 1'b1;
        @(negedge clk);
        shot_valid = 1'b0;
        for (int n = 1; n < 40; n++) begin
            if (res_valid) begin
                got = 1'b1; lat = n; h = res_hit; s = res_sink; d = res_dup;
                break;
            end
            if (eng_cord_valid) cords++;
            @(negedge clk);
        end
        if (got) @(negedge clk);
    endtask

    task automatic test_reset();
        rstn = 1'b0; start = 1'b0; shot_valid = 1'b0; board_sel = 2'd0; shot_x = '0; shot_y = '0;
        repeat (3) @(negedge clk);
        n_run++;
        if ({shot_ready, res_valid, res_hit, res_sink, res_dup, game_over, game_won, eng_rstn, eng_cord_valid} !== 9'b0) begin
            n_fail++; $display("FAIL reset_flags: got %09b want 000000000",
                {shot_ready, res_valid, res_hit, res_sink, res_dup, game_over, game_won, eng_rstn, eng_cord_valid});
        end
        n_run++;
        if (shots_used !== 6'd0 || hits !== 6'd0 || sinks !== 4'd0 || eng_x !== 3'd0 || eng_y !== 3'd0 || eng_init_select !== 2'd0) begin
            n_fail++; $display("FAIL reset_counts: shots=%0d hits=%0d sinks=%0d x=%0d y=%0d sel=%0d want all 0",
                shots_used, hits, sinks, eng_x, eng_y, eng_init_select);
        end
        rstn = 1'b1;
        shot_valid = 1'b1;
        repeat (4) begin
            @(negedge clk);
            n_run++;
            if (shot_ready !== 1'b0 || res_valid !== 1'b0 || eng_cord_valid !== 1'b0) begin
                n_fail++; $display("FAIL idle_ignore: ready=%0b res=%0b cord=%0b want 0 0 0", shot_ready, res_valid, eng_cord_valid);
            end
        end
        shot_valid = 1'b0;
    endtask

    task automatic test_hit();
        bit got; logic h, s, d; int lat, cords;
        do_start(2'd0);
        fire(3'd3, 3'd0, got, h, s, d, lat, cords);
        n_run++;
        if (!got || h !== 1'b1 || s !== 1'b0 || d !== 1'b0) begin
            n_fail++; $display("FAIL hit_result: got=%0b hit=%0b sink=%0b dup=%0b want 1 1 0 0", got, h, s, d);
        end
        n_run++;
        if (lat !== 6 || cords !== 1) begin
            n_fail++; $display("FAIL hit_timing: lat=%0d cords=%0d want 6 1", lat, cords);
        end
        n_run++;
        if (shots_used !== 6'd1 || hits !== 6'd1) begin
            n_fail++; $display("FAIL hit_counts: shots=%0d hits=%0d want 1 1", shots_used, hits);
        end
    endtask

    task automatic test_miss_dup();
        bit got; logic h, s, d; int lat, cords;
        fire(3'd0, 3'd0, got, h, s, d, lat, cords);
        n_run++;
        if (!got || h !== 1'b0 || d !== 1'b0 || shots_used !== 6'd2 || hits !== 6'd1) begin
            n_fail++; $display("FAIL miss: got=%0b hit=%0b dup=%0b shots=%0d hits=%0d want 1 0 0 2 1", got, h, d, shots_used, hits);
        end
        fire(3'd0, 3'd0, got, h, s, d, lat, cords);
        n_run++;
        if (!got || d !== 1'b1 || h !== 1'b0 || s !== 1'b0) begin
            n_fail++; $display("FAIL dup_result: got=%0b dup=%0b hit=%0b sink=%0b want 1 1 0 0", got, d, h, s);
        end
        n_run++;
        if (lat !== 2 || cords !== 0) begin
            n_fail++; $display("FAIL dup_timing: lat=%0d cords=%0d want 2 0", lat, cords);
        end
        n_run++;
        if (shots_used !== 6'd2 || hits !== 6'd1) begin
            n_fail++; $display("FAIL dup_counts: shots=%0d hits=%0d want 2 1", shots_used, hits);
        end
    endtask

    task automatic test_sink_win();
        bit got; logic h, s, d; int lat, cords;
        fire(3'd3, 3'd1, got, h, s, d, lat, cords);
        n_run++;
        if (!got || h !== 1'b1 || s !== 1'b1 || sinks !== 4'd1 || game_over !== 1'b0) begin
            n_fail++; $display("FAIL sink_a: got=%0b hit=%0b sink=%0b sinks=%0d over=%0b want 1 1 1 1 0", got, h, s, sinks, game_over);
        end
        // last ship sinks on the shot that also spends the budget: engine done must win
        fire(3'd5, 3'd5, got, h, s, d, lat, cords);
        n_run++;
        if (!got || h !== 1'b1 || s !== 1'b1 || sinks !== 4'd2 || hits !== 6'd3 || shots_used !== 6'd4) begin
            n_fail++; $display("FAIL sink_b: got=%0b hit=%0b sink=%0b sinks=%0d hits=%0d shots=%0d want 1 1 1 2 3 4",
                got, h, s, sinks, hits, shots_used);
        end
        n_run++;
        if (game_over !== 1'b1 || game_won !== 1'b1 || shot_ready !== 1'b0) begin
            n_fail++; $display("FAIL win: over=%0b won=%0b ready=%0b want 1 1 0", game_over, game_won, shot_ready);
        end
    endtask

    task automatic test_lose();
        bit got; logic h, s, d; int lat, cords; int seen;
        do_start(2'd0);
        n_run++;
        if (shots_used !== 6'd0 || hits !== 6'd0 || sinks !== 4'd0 || game_over !== 1'b0 || game_won !== 1'b0) begin
            n_fail++; $display("FAIL restart_clear: shots=%0d hits=%0d sinks=%0d over=%0b won=%0b want 0 0 0 0 0",
                shots_used, hits, sinks, game_over, game_won);
        end
        fire(3'd0, 3'd1, got, h, s, d, lat, cords);
        fire(3'd1, 3'd1, got, h, s, d, lat, cords);
        fire(3'd2, 3'd2, got, h, s, d, lat, cords);
        n_run++;
        if (game_over !== 1'b0 || shots_used !== 6'd3) begin
            n_fail++; $display("FAIL lose_pre: over=%0b shots=%0d want 0 3", game_over, shots_used);
        end
        fire(3'd7, 3'd7, got, h, s, d, lat, cords);
        n_run++;
        if (!got || game_over !== 1'b1 || game_won !== 1'b0 || shots_used !== 6'd4) begin
            n_fail++; $display("FAIL lose: got=%0b over=%0b won=%0b shots=%0d want 1 1 0 4", got, game_over, game_won, shots_used);
        end
        seen = 0;
        shot_x = 3'd6; shot_y = 3'd6; shot_valid = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (shot_ready || res_valid || eng_cord_valid) seen++;
        end
        shot_valid = 1'b0;
        n_run++;
        if (seen !== 0) begin n_fail++; $display("FAIL over_ignore: activity=%0d want 0", seen); end
    endtask

    task automatic test_abort();
        bit got; logic h, s, d; int lat, cords; int rst_cycles, res_seen;
        do_start(2'd0);
        busy_len = 10;
        shot_x = 3'd0; shot_y = 3'd0; shot_valid = 1'b1;
        @(negedge clk);
        shot_valid = 1'b0;
        repeat (3) @(negedge clk);
        n_run++;
        if (shots_used !== 6'd1 || res_valid !== 1'b0) begin
            n_fail++; $display("FAIL abort_pre: shots=%0d res=%0b want 1 0", shots_used, res_valid);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        rst_cycles = 0; res_seen = 0;
        repeat (15) begin
            if (!eng_rstn) rst_cycles++;
            if (res_valid) res_seen++;
            @(negedge clk);
        end
        busy_len = 2;
        n_run++;
        if (rst_cycles !== 1 || res_seen !== 0) begin
            n_fail++; $display("FAIL abort: eng_rstn_low=%0d results=%0d want 1 0", rst_cycles, res_seen);
        end
        n_run++;
        if (shots_used !== 6'd0 || hits !== 6'd0 || shot_ready !== 1'b1) begin
            n_fail++; $display("FAIL abort_clear: shots=%0d hits=%0d ready=%0b want 0 0 1", shots_used, hits, shot_ready);
        end
        // start and a shot in the same READY cycle: the shot must be dropped
        start = 1'b1; shot_valid = 1'b1; shot_x = 3'd0; shot_y = 3'd0;
        @(negedge clk);
        start = 1'b0; shot_valid = 1'b0;
        res_seen = 0;
        repeat (8) begin
            if (res_valid || eng_cord_valid) res_seen++;
            @(negedge clk);
        end
        n_run++;
        if (res_seen !== 0) begin n_fail++; $display("FAIL start_priority: activity=%0d want 0", res_seen); end
        fire(3'd0, 3'd0, got, h, s, d, lat, cords);
        n_run++;
        if (!got || d !== 1'b0 || h !== 1'b0 || cords !== 1 || shots_used !== 6'd1) begin
            n_fail++; $display("FAIL abort_bitmap: got=%0b dup=%0b hit=%0b cords=%0d shots=%0d want 1 0 0 1 1",
                got, d, h, cords, shots_used);
        end
    endtask

    task automatic test_timeout_rst();
        bit got; logic h, s, d; int lat, cords;
        no_busy = 1'b1;
        fire(3'd2, 3'd3, got, h, s, d, lat, cords);
        n_run++;
        if (!got || lat !== 8 || h !== 1'b0) begin
            n_fail++; $display("FAIL timeout_miss: got=%0b lat=%0d hit=%0b want 1 8 0", got, lat, h);
        end
        fire(3'd3, 3'd0, got, h, s, d, lat, cords);
        n_run++;
        if (!got || lat !== 8 || h !== 1'b1 || hits !== 6'd1) begin
            n_fail++; $display("FAIL timeout_hit: got=%0b lat=%0d hit=%0b hits=%0d want 1 8 1 1", got, lat, h, hits);
        end
        no_busy = 1'b0;
        shot_x = 3'd1; shot_y = 3'd2; shot_valid = 1'b1;
        @(negedge clk);
        shot_valid = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        n_run++;
        if ({shot_ready, res_valid, res_hit, res_dup, game_over, eng_rstn, eng_cord_valid} !== 7'b0 ||
            shots_used !== 6'd0 || hits !== 6'd0 || eng_x !== 3'd0 || eng_y !== 3'd0) begin
            n_fail++; $display("FAIL midshot_reset: flags=%07b shots=%0d hits=%0d x=%0d y=%0d want 0 0 0 0 0",
                {shot_ready, res_valid, res_hit, res_dup, game_over, eng_rstn, eng_cord_valid}, shots_used, hits, eng_x, eng_y);
        end
        rstn = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_hit();
        test_miss_dup();
        test_sink_win();
        test_lose();
        test_abort();
        test_timeout_rst();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
